// File: rtl/toy_bpu_fe_ctrl_if.sv
// Purpose: bundles the flow-control, flush, restart-handshake and credit signals of the BPU front-end controller.
// Latency: none; this is only a signal container.
// Backpressure: bpu_redirect_vld/bpu_redirect_rdy handshake; the controller uses the slave modport.
interface toy_bpu_fe_ctrl_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int CREDIT_DEPTH = 8
);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    logic                  be_redirect_vld;
    logic [ADDR_WIDTH-1:0] be_redirect_pc;
    logic                  ras_chgflw_vld;
    logic [ADDR_WIDTH-1:0] ras_chgflw_pc;
    logic                  filter_enqueue;
    logic [ADDR_WIDTH-1:0] filter_enqueue_pc;
    logic                  fq_dequeue;
    logic                  fe_ctrl_be_chgflw;
    logic                  fe_ctrl_ras_chgflw;
    logic                  flush;
    logic                  bpu_redirect_vld;
    logic                  bpu_redirect_rdy;
    logic [ADDR_WIDTH-1:0] bpu_redirect_pc;
    logic                  fetch_queue_rdy;
    logic [CW-1:0]         credit_cnt;
    logic [ADDR_WIDTH-1:0] last_enq_pc;
    logic                  err;

    // Driver side: the environment around the controller.
    modport master (
        output be_redirect_vld, be_redirect_pc, ras_chgflw_vld, ras_chgflw_pc,
        output filter_enqueue, filter_enqueue_pc, fq_dequeue, bpu_redirect_rdy,
        input  fe_ctrl_be_chgflw, fe_ctrl_ras_chgflw, flush, bpu_redirect_vld,
        input  bpu_redirect_pc, fetch_queue_rdy, credit_cnt, last_enq_pc, err
    );

    // Controller side.
    modport slave (
        input  be_redirect_vld, be_redirect_pc, ras_chgflw_vld, ras_chgflw_pc,
        input  filter_enqueue, filter_enqueue_pc, fq_dequeue, bpu_redirect_rdy,
        output fe_ctrl_be_chgflw, fe_ctrl_ras_chgflw, flush, bpu_redirect_vld,
        output bpu_redirect_pc, fetch_queue_rdy, credit_cnt, last_enq_pc, err
    );
endinterface

// File: rtl/toy_bpu_fe_ctrl.sv
// Purpose: arbitrates backend/RAS change-of-flow, flushes the queues, sequences the BPU restart, tracks fetch-queue credits.
// Latency: hold signals are combinational; flush one cycle after a redirect; restart request after FLUSH_CYCLES more (RAS: next cycle).
// Backpressure: restart request held until bpu_redirect_rdy; fetch_queue_rdy drops when no credits remain.
module toy_bpu_fe_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int CREDIT_DEPTH = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    toy_bpu_fe_ctrl_if.slave   bus
);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD  = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  flush_q, flush_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  err_q, err_d;

    logic be_chg;
    logic ras_chg;
    logic enq_acc;
    logic deq_acc;
    logic redir_acc;

    // Filter hold whenever a backend redirect is seen or a restart is in progress;
    // the RAS target is only selected in RUN and only when the backend is quiet.
    assign be_chg  = bus.be_redirect_vld | (state_q != ST_RUN);
    assign ras_chg = bus.ras_chgflw_vld & (state_q == ST_RUN) & ~bus.be_redirect_vld;
    assign enq_acc = bus.filter_enqueue & ~be_chg;
    assign deq_acc = bus.fq_dequeue & (state_q == ST_RUN);

    assign bus.fe_ctrl_be_chgflw  = be_chg;
    assign bus.fe_ctrl_ras_chgflw = ras_chg;
    assign bus.flush              = flush_q;
    assign bus.bpu_redirect_vld   = (state_q == ST_REDIRECT);
    assign bus.bpu_redirect_pc    = pc_q;
    assign bus.fetch_queue_rdy    = (credit_q != '0);
    assign bus.credit_cnt         = credit_q;
    assign bus.last_enq_pc        = last_q;
    assign bus.err                = err_q;

    // Next-state, restart-PC, flush pulse and credit bookkeeping.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pc_d      = pc_q;
        flush_d   = 1'b0;
        credit_d  = credit_q;
        last_d    = last_q;
        err_d     = err_q;
        redir_acc = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.be_redirect_vld) begin
                    pc_d      = bus.be_redirect_pc;
                    fcnt_d    = FLUSH_LOAD;
                    state_d   = ST_FLUSH;
                    redir_acc = 1'b1;
                end else if (bus.ras_chgflw_vld && bus.filter_enqueue) begin
                    // The corrected block already went in with the RAS target; only
                    // younger work must be dropped, so no FLUSH wait is needed.
                    pc_d      = bus.ras_chgflw_pc;
                    state_d   = ST_REDIRECT;
                    redir_acc = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (bus.be_redirect_vld) begin
                    pc_d      = bus.be_redirect_pc;
                    fcnt_d    = FLUSH_LOAD;
                    redir_acc = 1'b1;
                end else if (fcnt_q == '0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            ST_REDIRECT: begin
                // A backend redirect voids a coincident handshake.
                if (bus.be_redirect_vld) begin
                    pc_d      = bus.be_redirect_pc;
                    fcnt_d    = FLUSH_LOAD;
                    state_d   = ST_FLUSH;
                    redir_acc = 1'b1;
                end else if (bus.bpu_redirect_rdy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        flush_d = redir_acc;

        if (enq_acc) begin
            last_d = bus.filter_enqueue_pc;
        end

        if (redir_acc) begin
            credit_d = CREDIT_FULL;
        end else if (enq_acc && deq_acc) begin
            credit_d = credit_q;
        end else if (enq_acc) begin
            if (credit_q == '0) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q - CW'(1);
            end
        end else if (deq_acc) begin
            if (credit_q == CREDIT_FULL) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    // State and datapath registers; reset lands in RUN with a full credit pool.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            fcnt_q   <= '0;
            pc_q     <= '0;
            flush_q  <= 1'b0;
            credit_q <= CREDIT_FULL;
            last_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            credit_q <= credit_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_toy_bpu_fe_ctrl.sv
module tb_toy_bpu_fe_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    toy_bpu_fe_ctrl_if #(.ADDR_WIDTH(32), .CREDIT_DEPTH(8)) bif ();

    toy_bpu_fe_ctrl #(.ADDR_WIDTH(32), .CREDIT_DEPTH(8), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle time between driving inputs and sampling outputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bif.be_redirect_vld   = 1'b0;
        bif.ras_chgflw_vld    = 1'b0;
        bif.filter_enqueue    = 1'b0;
        bif.fq_dequeue        = 1'b0;
        bif.bpu_redirect_rdy  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        bif.be_redirect_pc    = '0;
        bif.ras_chgflw_pc     = '0;
        bif.filter_enqueue_pc = '0;

        // Reset values
        tick(); tick();
        settle();
        chk("rst_credit", 64'(bif.credit_cnt), 64'd8);
        chk("rst_fq_rdy", 64'(bif.fetch_queue_rdy), 64'd1);
        chk("rst_flush", 64'(bif.flush), 64'd0);
        chk("rst_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        chk("rst_err", 64'(bif.err), 64'd0);
        chk("rst_pc", 64'(bif.bpu_redirect_pc), 64'd0);
        chk("rst_last", 64'(bif.last_enq_pc), 64'd0);
        chk("rst_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd0);
        chk("rst_ras_chg", 64'(bif.fe_ctrl_ras_chgflw), 64'd0);
        rst = 1'b0;

        // Credit drain: 8 enqueues
        for (int i = 0; i < 8; i++) begin
            tick();
            bif.filter_enqueue    = 1'b1;
            bif.filter_enqueue_pc = 32'h100 + 32'(i);
        end
        tick();
        idle_inputs();
        settle();
        chk("drain_credit", 64'(bif.credit_cnt), 64'd0);
        chk("drain_fq_rdy", 64'(bif.fetch_queue_rdy), 64'd0);
        chk("drain_last", 64'(bif.last_enq_pc), 64'h107);

        // Enqueue + dequeue at zero credit
        tick();
        bif.filter_enqueue    = 1'b1;
        bif.filter_enqueue_pc = 32'h200;
        bif.fq_dequeue        = 1'b1;
        tick();
        idle_inputs();
        settle();
        chk("encdeq_credit", 64'(bif.credit_cnt), 64'd0);
        chk("encdeq_err", 64'(bif.err), 64'd0);
        chk("encdeq_last", 64'(bif.last_enq_pc), 64'h200);

        // Ninth enqueue alone: underflow error, count holds
        tick();
        bif.filter_enqueue    = 1'b1;
        bif.filter_enqueue_pc = 32'h204;
        tick();
        idle_inputs();
        settle();
        chk("under_err", 64'(bif.err), 64'd1);
        chk("under_credit", 64'(bif.credit_cnt), 64'd0);

        // Dequeue alone returns one credit, err stays sticky
        tick();
        bif.fq_dequeue = 1'b1;
        tick();
        idle_inputs();
        settle();
        chk("deq_credit", 64'(bif.credit_cnt), 64'd1);
        chk("deq_err_sticky", 64'(bif.err), 64'd1);

        // Backend redirect at T
        tick();
        bif.be_redirect_vld = 1'b1;
        bif.be_redirect_pc  = 32'h8000_1000;
        settle();
        chk("be_T_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd1);
        chk("be_T_flush", 64'(bif.flush), 64'd0);
        tick(); // T+1
        idle_inputs();
        settle();
        chk("be_T1_flush", 64'(bif.flush), 64'd1);
        chk("be_T1_credit", 64'(bif.credit_cnt), 64'd8);
        chk("be_T1_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd1);
        chk("be_T1_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        tick(); // T+2
        settle();
        chk("be_T2_flush", 64'(bif.flush), 64'd0);
        chk("be_T2_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        tick(); // T+3
        settle();
        chk("be_T3_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        chk("be_T3_pc", 64'(bif.bpu_redirect_pc), 64'h8000_1000);
        tick(); // T+4
        settle();
        chk("be_T4_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        tick(); // T+5
        bif.bpu_redirect_rdy = 1'b1;
        settle();
        chk("be_T5_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        chk("be_T5_pc", 64'(bif.bpu_redirect_pc), 64'h8000_1000);
        tick(); // T+6
        idle_inputs();
        settle();
        chk("be_T6_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd0);
        chk("be_T6_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        chk("be_T6_credit", 64'(bif.credit_cnt), 64'd8);

        // RAS without enqueue: no state change
        tick();
        bif.ras_chgflw_vld = 1'b1;
        bif.ras_chgflw_pc  = 32'h3000_0000;
        settle();
        chk("rasnoenq_chg", 64'(bif.fe_ctrl_ras_chgflw), 64'd1);
        tick();
        idle_inputs();
        settle();
        chk("rasnoenq_flush", 64'(bif.flush), 64'd0);
        chk("rasnoenq_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd0);

        // RAS redirect with enqueue
        tick();
        bif.filter_enqueue    = 1'b1;
        bif.filter_enqueue_pc = 32'h300;
        tick();
        bif.filter_enqueue_pc = 32'h304;
        bif.ras_chgflw_vld    = 1'b1;
        bif.ras_chgflw_pc     = 32'h2000_0040;
        settle();
        chk("ras_T_chg", 64'(bif.fe_ctrl_ras_chgflw), 64'd1);
        chk("ras_T_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd0);
        chk("ras_T_credit", 64'(bif.credit_cnt), 64'd7);
        tick();
        idle_inputs();
        settle();
        chk("ras_T1_flush", 64'(bif.flush), 64'd1);
        chk("ras_T1_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        chk("ras_T1_pc", 64'(bif.bpu_redirect_pc), 64'h2000_0040);
        chk("ras_T1_credit", 64'(bif.credit_cnt), 64'd8);
        chk("ras_T1_last", 64'(bif.last_enq_pc), 64'h304);
        tick();
        bif.ras_chgflw_vld   = 1'b1;
        bif.bpu_redirect_rdy = 1'b1;
        settle();
        chk("ras_T2_ignored", 64'(bif.fe_ctrl_ras_chgflw), 64'd0);
        chk("ras_T2_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        tick();
        idle_inputs();
        settle();
        chk("ras_T3_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        chk("ras_T3_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd0);
        chk("ras_T3_flush", 64'(bif.flush), 64'd0);

        // Simultaneous backend + RAS: backend wins, goes through FLUSH
        tick();
        bif.be_redirect_vld   = 1'b1;
        bif.be_redirect_pc    = 32'h9000_0000;
        bif.ras_chgflw_vld    = 1'b1;
        bif.ras_chgflw_pc     = 32'h1111_0000;
        bif.filter_enqueue    = 1'b1;
        bif.filter_enqueue_pc = 32'h400;
        settle();
        chk("sim_ras_chg", 64'(bif.fe_ctrl_ras_chgflw), 64'd0);
        chk("sim_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd1);
        tick();
        idle_inputs();
        settle();
        chk("sim_T1_flush", 64'(bif.flush), 64'd1);
        chk("sim_T1_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        chk("sim_T1_last", 64'(bif.last_enq_pc), 64'h304);
        tick();
        settle();
        chk("sim_T2_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        tick();
        settle();
        chk("sim_T3_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        chk("sim_T3_pc", 64'(bif.bpu_redirect_pc), 64'h9000_0000);

        // Backend redirect coincident with rdy in REDIRECT
        tick();
        bif.be_redirect_vld  = 1'b1;
        bif.be_redirect_pc   = 32'hA000_0000;
        bif.bpu_redirect_rdy = 1'b1;
        settle();
        chk("rr_T_pc_old", 64'(bif.bpu_redirect_pc), 64'h9000_0000);
        tick();
        idle_inputs();
        settle();
        chk("rr_T1_flush", 64'(bif.flush), 64'd1);
        chk("rr_T1_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        chk("rr_T1_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd1);
        tick();
        settle();
        chk("rr_T2_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        tick();
        settle();
        chk("rr_T3_vld", 64'(bif.bpu_redirect_vld), 64'd1);
        chk("rr_T3_pc", 64'(bif.bpu_redirect_pc), 64'hA000_0000);

        // Complete, then reset mid-FLUSH
        tick();
        bif.bpu_redirect_rdy = 1'b1;
        tick();
        idle_inputs();
        bif.be_redirect_vld = 1'b1;
        bif.be_redirect_pc  = 32'hB000_0000;
        tick();
        idle_inputs();
        settle();
        chk("mr_flush_pre", 64'(bif.flush), 64'd1);
        rst = 1'b1;
        settle();
        chk("mr_flush", 64'(bif.flush), 64'd0);
        chk("mr_be_chg", 64'(bif.fe_ctrl_be_chgflw), 64'd0);
        chk("mr_credit", 64'(bif.credit_cnt), 64'd8);
        chk("mr_err", 64'(bif.err), 64'd0);
        chk("mr_pc", 64'(bif.bpu_redirect_pc), 64'd0);
        chk("mr_last", 64'(bif.last_enq_pc), 64'd0);
        chk("mr_vld", 64'(bif.bpu_redirect_vld), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("post_rst_vld", 64'(bif.bpu_redirect_vld), 64'd0);
            chk("post_rst_flush", 64'(bif.flush), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/toy_bpu_fe_ctrl.md
# toy_bpu_fe_ctrl

Front-end flow controller for the BPU filter stage. It arbitrates the two change-of-flow sources, backend redirect and RAS correction, and drives the filter's `fe_ctrl_be_chgflw` / `fe_ctrl_ras_chgflw` hold signals. It also flushes the BTFIFO/ROB/fetch queue, sequences the BPU restart handshake, and keeps the fetch-queue credit counter that produces `fetch_queue_rdy`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC width.
- `CREDIT_DEPTH`, default 8: fetch-queue entries; the initial credit value.
- `FLUSH_CYCLES`, default 2: number of cycles held in FLUSH; must be ≥1.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `be_redirect_vld`  in  1  backend mispredict/exception redirect.
- `be_redirect_pc`  in  ADDR_WIDTH  backend restart PC.
- `ras_chgflw_vld`  in  1  RAS target differs from the BTB target for the block at the filter.
- `ras_chgflw_pc`  in  ADDR_WIDTH  RAS-corrected next PC.
- `filter_enqueue`  in  1  filter consumed a block (`fe_ctrl_enqueue`).
- `filter_enqueue_pc`  in  ADDR_WIDTH  `pred_pc` of the consumed block.
- `fq_dequeue`  in  1  fetch queue popped one entry.
- `fe_ctrl_be_chgflw`  out  1  filter hold/kill.
- `fe_ctrl_ras_chgflw`  out  1  filter selects the RAS target.
- `flush`  out  1  one-cycle flush to BTFIFO, ROB and fetch queue.
- `bpu_redirect_vld`  out  1  restart request to the BPU.
- `bpu_redirect_rdy`  in  1  BPU accepts the restart.
- `bpu_redirect_pc`  out  ADDR_WIDTH  restart PC.
- `fetch_queue_rdy`  out  1  high when `credit_cnt != 0`.
- `credit_cnt`  out  $clog2(CREDIT_DEPTH+1)  free fetch-queue entries.
- `last_enq_pc`  out  ADDR_WIDTH  PC of the most recent accepted enqueue.
- `err`  out  1  sticky protocol-error flag.

## Operation
States are RUN, FLUSH and REDIRECT. Reset puts the block in RUN.

Reset values:
- `credit_cnt` = CREDIT_DEPTH and `fetch_queue_rdy` = 1.
- `flush`, `bpu_redirect_vld`, `err` = 0; `bpu_redirect_pc` and `last_enq_pc` = 0.
- Combinational outputs are 0 while their inputs are low.

Combinational outputs:
- `fe_ctrl_be_chgflw = be_redirect_vld | (state != RUN)`.
- `fe_ctrl_ras_chgflw = ras_chgflw_vld & (state == RUN) & ~be_redirect_vld`.

RUN:
- On `be_redirect_vld`: latch `be_redirect_pc`, pulse `flush` next cycle, load the flush counter with FLUSH_CYCLES-1, go to FLUSH. This has priority over RAS.
- Else on `ras_chgflw_vld & filter_enqueue`: latch `ras_chgflw_pc`, pulse `flush` next cycle, go to REDIRECT. The corrected block itself is kept; it was enqueued with the RAS target.
- `ras_chgflw_vld` without `filter_enqueue` causes no state change.

FLUSH:
- The counter decrements each cycle. At 0, go to REDIRECT.
- A new `be_redirect_vld` overwrites the PC, reloads the counter and re-pulses `flush`.

REDIRECT:
- `bpu_redirect_vld` = 1 with the latched PC.
- On `bpu_redirect_rdy`, go to RUN the following cycle.
- A `be_redirect_vld` arriving here, including in the same cycle as `rdy`, wins: the handshake is void, the PC is overwritten, `flush` is pulsed, and the block goes to FLUSH.
- RAS events are ignored outside RUN.

Credits:
- An accepted enqueue (`filter_enqueue & ~fe_ctrl_be_chgflw`) decrements `credit_cnt`. `fq_dequeue` increments it. Both in the same cycle leave it unchanged.
- On any redirect acceptance, the next value is CREDIT_DEPTH (queue flushed). Enqueues and dequeues in that cycle are discarded.
- While in FLUSH or REDIRECT, `fq_dequeue` is ignored.
- Protocol errors set `err`, which is sticky until reset, and the count holds:
  - enqueue at credit 0 (no underflow);
  - dequeue at CREDIT_DEPTH without an enqueue (no overflow).
- `last_enq_pc` updates on every accepted enqueue.

## Timing
- Backend redirect at cycle T:
  - `fe_ctrl_be_chgflw` is high in T.
  - `flush` is high in T+1 and `credit_cnt` = CREDIT_DEPTH in T+1.
  - FLUSH occupies T+1 .. T+FLUSH_CYCLES.
  - `bpu_redirect_vld` first rises in T+FLUSH_CYCLES+1.
- RAS redirect at T:
  - `fe_ctrl_ras_chgflw` is high in T.
  - `flush` and `bpu_redirect_vld` are high in T+1.
- Handshake completes in the cycle with `vld & rdy`. RUN is entered next cycle; `fe_ctrl_be_chgflw` drops that cycle.
- `bpu_redirect_vld` and `bpu_redirect_pc` are stable until accepted or superseded by a backend redirect.
- Asynchronous reset mid-sequence returns the block to RUN with the reset values immediately. No `flush` is emitted.

## Test plan
- Credit count: with no redirects, 8 enqueues → `credit_cnt` 0 and `fetch_queue_rdy` 0. Then enqueue + dequeue in the same cycle → stays 0, `err` stays 0. A 9th enqueue alone → `err` = 1, count stays 0.
- Backend redirect: `be_redirect_vld` with PC 0x8000_1000 at T, FLUSH_CYCLES=2 → `flush` at T+1; `bpu_redirect_vld` at T+3 with PC 0x8000_1000; `rdy` at T+5 → RUN at T+6, `fe_ctrl_be_chgflw` low at T+6.
- RAS redirect: `ras_chgflw_vld` + `filter_enqueue`, RAS PC 0x2000_0040 → `fe_ctrl_ras_chgflw` same cycle; `flush` and REDIRECT next cycle with PC 0x2000_0040; credits back to 8.
- Simultaneous sources: `be_redirect_vld` and `ras_chgflw_vld` in the same cycle → `fe_ctrl_ras_chgflw` = 0; latched PC is the backend PC; path goes through FLUSH.
- Redirect during restart: backend redirect in REDIRECT coincident with `rdy` → handshake ignored, new PC latched, FLUSH re-entered, second `flush` pulse.
- Reset mid-FLUSH: assert `rst` → all outputs at reset values immediately, `credit_cnt` = 8, no `bpu_redirect_vld` after release.
